// File: rtl/uarc_receive_arbiter.sv
// uarc_receive_arbiter
//   Receiver-side scheduler for core0's UARC buses. Watches kill / incept /
//   send requests on every receiver bus, picks one bus at a time with
//   round-robin fairness, offers it to the dispatch logic over a valid/ready
//   grant interface and pulses a single-cycle ack back on the chosen bus
//   once the core accepts.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   receiver_enables             bus i is connected and live
//   receiver_kills/incepts/sends request lines per bus
//   receiver_*_acks              one-cycle ack pulse per bus (from state ACK)
//   receiver_datas               packed send data, WORD_WIDTH per bus
//   receiver_incept_permissions  packed incept permission per bus
//   receiver_incept_addresses    packed incept address per bus
//   grant_valid / grant_ready    offer handshake towards the core
//   grant_kind                   0 = kill, 1 = incept, 2 = send
//   grant_bus                    index of the offered bus
//   grant_data/permission/address words latched when the bus was chosen
//   debug_state, debug_ptr       FSM state and round-robin pointer
//
// Handshake: while in OFFER, grant_valid follows the offered request line
// combinationally; a transfer happens on a rising edge where grant_valid
// and grant_ready are both high. Latched fields are stable while
// grant_valid is high. If the sender retracts, grant_valid drops and the
// offer is abandoned without an ack.

module uarc_receive_arbiter #(
  parameter int WORD_MAG = 5,
  parameter int TOTAL_BUSES = 4,
  localparam int WORD_WIDTH = 1 << WORD_MAG,
  localparam int BUS_ADDR_WIDTH = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [TOTAL_BUSES-1:0]              receiver_enables,
  input  logic [TOTAL_BUSES-1:0]              receiver_kills,
  output logic [TOTAL_BUSES-1:0]              receiver_kill_acks,
  input  logic [TOTAL_BUSES-1:0]              receiver_incepts,
  output logic [TOTAL_BUSES-1:0]              receiver_incept_acks,
  input  logic [TOTAL_BUSES-1:0]              receiver_sends,
  output logic [TOTAL_BUSES-1:0]              receiver_send_acks,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0]   receiver_datas,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0]   receiver_incept_permissions,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0]   receiver_incept_addresses,
  output logic                                grant_valid,
  input  logic                                grant_ready,
  output logic [1:0]                          grant_kind,
  output logic [BUS_ADDR_WIDTH-1:0]           grant_bus,
  output logic [WORD_WIDTH-1:0]               grant_data,
  output logic [WORD_WIDTH-1:0]               grant_permission,
  output logic [WORD_WIDTH-1:0]               grant_address,
  output logic [1:0]                          debug_state,
  output logic [BUS_ADDR_WIDTH-1:0]           debug_ptr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam logic [1:0] KIND_KILL   = 2'd0;
  localparam logic [1:0] KIND_INCEPT = 2'd1;
  localparam logic [1:0] KIND_SEND   = 2'd2;

  logic [1:0]                state;
  logic [BUS_ADDR_WIDTH-1:0] ptr;
  logic [BUS_ADDR_WIDTH-1:0] bus_q;
  logic [1:0]                kind_q;
  logic [WORD_WIDTH-1:0]     data_q;
  logic [WORD_WIDTH-1:0]     perm_q;
  logic [WORD_WIDTH-1:0]     addr_q;

  logic [TOTAL_BUSES-1:0]    req;
  logic [WORD_WIDTH-1:0]     data_w [TOTAL_BUSES];
  logic [WORD_WIDTH-1:0]     perm_w [TOTAL_BUSES];
  logic [WORD_WIDTH-1:0]     addr_w [TOTAL_BUSES];

  logic                      sel_found;
  logic [BUS_ADDR_WIDTH-1:0] sel_bus;
  logic [1:0]                sel_kind;
  int                        idx;
  logic                      still;
  logic [BUS_ADDR_WIDTH-1:0] ptr_next;

  assign req = receiver_enables &
               (receiver_kills | receiver_incepts | receiver_sends);

  for (genvar g = 0; g < TOTAL_BUSES; g++) begin : g_unpack
    assign data_w[g] = receiver_datas[g*WORD_WIDTH +: WORD_WIDTH];
    assign perm_w[g] = receiver_incept_permissions[g*WORD_WIDTH +: WORD_WIDTH];
    assign addr_w[g] = receiver_incept_addresses[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // First requesting bus at or after ptr. The wrap is at TOTAL_BUSES, so a
  // non-power-of-two bus count never aliases onto a nonexistent index.
  always_comb begin
    sel_found = 1'b0;
    sel_bus   = '0;
    idx       = 0;
    for (int k = 0; k < TOTAL_BUSES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= TOTAL_BUSES) idx = idx - TOTAL_BUSES;
      if (!sel_found && req[idx[BUS_ADDR_WIDTH-1:0]]) begin
        sel_found = 1'b1;
        sel_bus   = idx[BUS_ADDR_WIDTH-1:0];
      end
    end
  end

  // Kill outranks incept, incept outranks send.
  assign sel_kind = receiver_kills[sel_bus]   ? KIND_KILL :
                    receiver_incepts[sel_bus] ? KIND_INCEPT : KIND_SEND;

  // The offer survives only while the exact request line it was taken
  // from stays asserted on a still-enabled bus.
  always_comb begin
    still = 1'b0;
    case (kind_q)
      KIND_KILL:   still = receiver_kills[bus_q];
      KIND_INCEPT: still = receiver_incepts[bus_q];
      default:     still = receiver_sends[bus_q];
    endcase
    still = still & receiver_enables[bus_q];
  end

  assign ptr_next = (bus_q == BUS_ADDR_WIDTH'(TOTAL_BUSES - 1)) ? '0 : bus_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      bus_q  <= '0;
      kind_q <= KIND_KILL;
      data_q <= '0;
      perm_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state  <= ST_OFFER;
            bus_q  <= sel_bus;
            kind_q <= sel_kind;
            data_q <= data_w[sel_bus];
            perm_q <= perm_w[sel_bus];
            addr_q <= addr_w[sel_bus];
          end
        end
        ST_OFFER: begin
          if (!still) begin
            state <= ST_IDLE;
          end else if (grant_ready) begin
            state <= ST_ACK;
            ptr   <= ptr_next;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Acks decode from registered state only, so they never follow inputs
  // combinationally and vanish at once when reset is asserted.
  always_comb begin
    receiver_kill_acks   = '0;
    receiver_incept_acks = '0;
    receiver_send_acks   = '0;
    if (state == ST_ACK) begin
      case (kind_q)
        KIND_KILL:   receiver_kill_acks[bus_q]   = 1'b1;
        KIND_INCEPT: receiver_incept_acks[bus_q] = 1'b1;
        default:     receiver_send_acks[bus_q]   = 1'b1;
      endcase
    end
  end

  assign grant_valid      = (state == ST_OFFER) & still;
  assign grant_kind       = kind_q;
  assign grant_bus        = bus_q;
  assign grant_data       = data_q;
  assign grant_permission = perm_q;
  assign grant_address    = addr_q;
  assign debug_state      = state;
  assign debug_ptr        = ptr;

endmodule

// File: tb/tb_uarc_receive_arbiter.sv
// Bench for uarc_receive_arbiter: a 4-bus instance (a_*) driven from a
// per-cycle vector table plus hand sequences for backpressure, retraction
// and reset, and a 3-bus instance (b_*) for the disabled-bus wrap case.
// Every ack pulse seen on either instance is matched against exp_q.

module tb_uarc_receive_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-bus instance
  logic [3:0]     a_en, a_kill, a_inc, a_snd, a_kack, a_iack, a_sack;
  logic [4*W-1:0] a_datas, a_perms, a_addrs;
  logic           a_rdy, a_valid;
  logic [1:0]     a_kind, a_bus, a_state, a_ptr;
  logic [W-1:0]   a_data, a_perm, a_addr;

  // 3-bus instance
  logic [2:0]     b_en, b_kill, b_inc, b_snd, b_kack, b_iack, b_sack;
  logic [3*W-1:0] b_datas, b_perms, b_addrs;
  logic           b_rdy, b_valid;
  logic [1:0]     b_kind, b_bus, b_state, b_ptr;
  logic [W-1:0]   b_data, b_perm, b_addr;

  logic [W-1:0] a_dat_c [4] = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hDEAD_BEEF, 32'hC3C3_0003};
  logic [W-1:0] a_prm_c [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
  logic [W-1:0] a_adr_c [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
  logic [W-1:0] b_dat_c [3] = '{32'h5555_0000, 32'h6666_0001, 32'h7777_0002};

  uarc_receive_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(4)) dut_a (
    .clk(clk), .reset(reset),
    .receiver_enables(a_en),
    .receiver_kills(a_kill), .receiver_kill_acks(a_kack),
    .receiver_incepts(a_inc), .receiver_incept_acks(a_iack),
    .receiver_sends(a_snd), .receiver_send_acks(a_sack),
    .receiver_datas(a_datas),
    .receiver_incept_permissions(a_perms),
    .receiver_incept_addresses(a_addrs),
    .grant_valid(a_valid), .grant_ready(a_rdy),
    .grant_kind(a_kind), .grant_bus(a_bus),
    .grant_data(a_data), .grant_permission(a_perm), .grant_address(a_addr),
    .debug_state(a_state), .debug_ptr(a_ptr)
  );

  uarc_receive_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(3)) dut_b (
    .clk(clk), .reset(reset),
    .receiver_enables(b_en),
    .receiver_kills(b_kill), .receiver_kill_acks(b_kack),
    .receiver_incepts(b_inc), .receiver_incept_acks(b_iack),
    .receiver_sends(b_snd), .receiver_send_acks(b_sack),
    .receiver_datas(b_datas),
    .receiver_incept_permissions(b_perms),
    .receiver_incept_addresses(b_addrs),
    .grant_valid(b_valid), .grant_ready(b_rdy),
    .grant_kind(b_kind), .grant_bus(b_bus),
    .grant_data(b_data), .grant_permission(b_perm), .grant_address(b_addr),
    .debug_state(b_state), .debug_ptr(b_ptr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {dut (0 = a, 1 = b), kind, bus}
  logic [4:0] exp_q[$];

  typedef struct {
    logic [3:0] en, kill, inc, snd;
    logic       rdy;
    logic       valid;
    logic [1:0] kind, bus;
    logic [3:0] kack, iack, sack;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] en, kill, inc, snd, input logic rdy,
                              input logic valid, input logic [1:0] kind, bus,
                              input logic [3:0] kack, iack, sack, input logic [1:0] ptr);
    vec_t v;
    v.en = en; v.kill = kill; v.inc = inc; v.snd = snd; v.rdy = rdy;
    v.valid = valid; v.kind = kind; v.bus = bus;
    v.kack = kack; v.iack = iack; v.sack = sack; v.ptr = ptr;
    return v;
  endfunction

  task automatic expect_ack(input logic dut, input logic [1:0] kind, input logic [1:0] bus);
    exp_q.push_back({dut, kind, bus});
  endtask

  // Entered at posedge+1: drive, compare at negedge, advance to posedge+1.
  task automatic apply_row(input vec_t v, input int r);
    a_en = v.en; a_kill = v.kill; a_inc = v.inc; a_snd = v.snd; a_rdy = v.rdy;
    @(negedge clk);
    check($sformatf("row%0d_valid", r), W'(a_valid), W'(v.valid));
    check($sformatf("row%0d_kill_acks", r), W'(a_kack), W'(v.kack));
    check($sformatf("row%0d_incept_acks", r), W'(a_iack), W'(v.iack));
    check($sformatf("row%0d_send_acks", r), W'(a_sack), W'(v.sack));
    check($sformatf("row%0d_ptr", r), W'(a_ptr), W'(v.ptr));
    if (v.valid) begin
      check($sformatf("row%0d_kind", r), W'(a_kind), W'(v.kind));
      check($sformatf("row%0d_bus", r), W'(a_bus), W'(v.bus));
      check($sformatf("row%0d_data", r), a_data, a_dat_c[v.bus]);
      check($sformatf("row%0d_perm", r), a_perm, a_prm_c[v.bus]);
      check($sformatf("row%0d_addr", r), a_addr, a_adr_c[v.bus]);
    end
    @(posedge clk); #1;
  endtask

  task automatic mon(input logic dut, input logic [3:0] k, input logic [3:0] i, input logic [3:0] s);
    int nb;
    logic [1:0] kd;
    logic [1:0] bi;
    logic [3:0] any;
    logic [4:0] exp;
    nb = $countones({k, i, s});
    if (nb == 0) return;
    n_checks++;
    if (nb != 1) begin
      n_fail++;
      $display("FAIL ack_onehot dut%0d: kill=%b incept=%b send=%b, expected one bit", dut, k, i, s);
      return;
    end
    kd  = (k != 0) ? 2'd0 : (i != 0) ? 2'd1 : 2'd2;
    any = k | i | s;
    bi  = 2'd0;
    for (int j = 0; j < 4; j++) if (any[j]) bi = 2'(j);
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL ack_unexpected dut%0d: kind=%0d bus=%0d, expected no ack", dut, kd, bi);
    end else begin
      exp = exp_q.pop_front();
      if ({dut, kd, bi} !== exp) begin
        n_fail++;
        $display("FAIL ack_order: got dut%0d kind=%0d bus=%0d, expected dut%0d kind=%0d bus=%0d",
                 dut, kd, bi, exp[4], exp[3:2], exp[1:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(1'b0, a_kack, a_iack, a_sack);
      mon(1'b1, {1'b0, b_kack}, {1'b0, b_iack}, {1'b0, b_sack});
    end
  end

  initial begin
    reset = 1'b1;
    a_en = 4'hF; a_kill = '0; a_inc = '0; a_snd = '0; a_rdy = 1'b0;
    b_en = 3'b111; b_kill = '0; b_inc = '0; b_snd = '0; b_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_datas[i*W +: W] = a_dat_c[i];
      a_perms[i*W +: W] = a_prm_c[i];
      a_addrs[i*W +: W] = a_adr_c[i];
    end
    for (int i = 0; i < 3; i++) begin
      b_datas[i*W +: W] = b_dat_c[i];
      b_perms[i*W +: W] = 32'h20 + W'(i);
      b_addrs[i*W +: W] = 32'h8000 + W'(i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", W'(a_valid), 0);
    check("rst_a_state", W'(a_state), 0);
    check("rst_a_ptr", W'(a_ptr), 0);
    check("rst_a_acks", W'({a_kack, a_iack, a_sack}), 0);
    check("rst_a_kind_bus", W'({a_kind, a_bus}), 0);
    check("rst_a_data", a_data, 0);
    check("rst_a_perm", a_perm, 0);
    check("rst_a_addr", a_addr, 0);
    check("rst_b_valid", W'(b_valid), 0);
    check("rst_b_ptr", W'(b_ptr), 0);
    check("rst_b_acks", W'({b_kack, b_iack, b_sack}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Round-robin over buses 0,1,3
    for (int r = 0; r < 19; r++) begin
      logic [3:0] s;
      logic [3:0] ack;
      logic       v;
      logic [1:0] bus;
      logic [1:0] p;
      s   = (r >= 17) ? 4'b0000 : 4'b1011;
      v   = (r % 3 == 1) && (r < 18);
      bus = 2'd0;
      ack = 4'b0000;
      case (r / 3)
        0, 3: bus = 2'd0;
        1, 4: bus = 2'd1;
        default: bus = 2'd3;
      endcase
      if (r % 3 == 2) ack = 4'b0001 << bus;
      // ptr moves to granted bus + 1 at the edge ending the OFFER cycle
      case (r)
        0, 1, 9, 10, 18: p = 2'd0;
        2, 3, 4, 11, 12, 13: p = 2'd1;
        5, 6, 7, 14, 15, 16: p = 2'd2;
        default: p = 2'd0;
      endcase
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, s, 1'b1, v, 2'd2, bus, 4'h0, 4'h0, ack, p));
    end
    // Single send on bus 2
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'b0100, 1, 0, 2, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'b0100, 1, 1, 2, 2, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'b0000, 1, 0, 2, 0, 0, 0, 4'b0100, 2'd3));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'b0000, 1, 0, 2, 0, 0, 0, 4'b0000, 2'd3));
    // Kind priority on bus 1
    tbl.push_back(mk(4'hF, 4'b0010, 4'b0010, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 2'd3));
    tbl.push_back(mk(4'hF, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 1, 0, 0, 0, 2'd3));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 0, 4'b0010, 0, 0, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0010, 4'b0010, 1, 1, 1, 1, 0, 0, 0, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 4'b0010, 0, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0000, 4'b0010, 1, 1, 2, 1, 0, 0, 0, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0010, 2'd2));
    tbl.push_back(mk(4'hF, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 2'd2));

    expect_ack(0, 2, 0); expect_ack(0, 2, 1); expect_ack(0, 2, 3);
    expect_ack(0, 2, 0); expect_ack(0, 2, 1); expect_ack(0, 2, 3);
    expect_ack(0, 2, 2);
    expect_ack(0, 0, 1); expect_ack(0, 1, 1); expect_ack(0, 2, 1);

    foreach (tbl[r]) apply_row(tbl[r], r);

    // Backpressure then retraction on bus 3 (ptr = 2)
    a_snd = 4'b1000; a_rdy = 1'b0;
    @(negedge clk);
    check("bp_idle_valid", W'(a_valid), 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) a_kill = 4'b0001;  // late kill on bus 0 must not preempt
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), W'(a_valid), 1);
      check($sformatf("bp%0d_bus", c), W'(a_bus), 3);
      check($sformatf("bp%0d_kind", c), W'(a_kind), 2);
      check($sformatf("bp%0d_data", c), a_data, a_dat_c[3]);
      check($sformatf("bp%0d_acks", c), W'({a_kack, a_iack, a_sack}), 0);
      @(posedge clk); #1;
    end
    a_snd = 4'b0000; a_kill = 4'b0000;
    @(negedge clk);
    check("retract_valid", W'(a_valid), 0);
    check("retract_acks", W'({a_kack, a_iack, a_sack}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("retract_state", W'(a_state), 0);
    check("retract_ptr", W'(a_ptr), 2);
    check("retract_acks2", W'({a_kack, a_iack, a_sack}), 0);
    @(posedge clk); #1;

    // Reset while offering bus 0
    a_snd = 4'b0001; a_rdy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_valid", W'(a_valid), 1);
    check("pre_rst_bus", W'(a_bus), 0);
    reset = 1'b1;
    #1;
    check("async_rst_valid", W'(a_valid), 0);
    check("async_rst_acks", W'({a_kack, a_iack, a_sack}), 0);
    check("async_rst_state", W'(a_state), 0);
    check("async_rst_ptr", W'(a_ptr), 0);
    check("async_rst_data", a_data, 0);
    @(posedge clk); #1;
    check("held_rst_valid", W'(a_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_valid", W'(a_valid), 1);
    check("post_rst_bus", W'(a_bus), 0);
    check("post_rst_kind", W'(a_kind), 2);
    check("post_rst_data", a_data, a_dat_c[0]);
    check("post_rst_acks", W'({a_kack, a_iack, a_sack}), 0);
    expect_ack(0, 2, 0);
    @(posedge clk); #1;
    check("post_rst_noack", W'(a_sack), 0);
    a_rdy = 1'b1;
    @(posedge clk); #1;
    a_snd = 4'b0000; a_rdy = 1'b0;
    @(negedge clk);
    check("post_rst_ack", W'(a_sack), 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_ptr", W'(a_ptr), 1);
    @(posedge clk); #1;

    // 3-bus instance: reach ptr = 2, then disable bus 2 and check wrap to 0
    expect_ack(1, 2, 1);
    expect_ack(1, 2, 0);
    b_snd = 3'b010; b_rdy = 1'b1;
    @(negedge clk);
    check("b_c0_valid", W'(b_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_c1_valid", W'(b_valid), 1);
    check("b_c1_bus", W'(b_bus), 1);
    check("b_c1_data", b_data, b_dat_c[1]);
    @(posedge clk); #1;
    b_snd = 3'b000;
    @(negedge clk);
    check("b_c2_ack", W'(b_sack), 3'b010);
    check("b_c2_ptr", W'(b_ptr), 2);
    @(posedge clk); #1;
    b_en = 3'b011; b_snd = 3'b111;
    @(negedge clk);
    check("b_c3_valid", W'(b_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_wrap_valid", W'(b_valid), 1);
    check("b_wrap_bus", W'(b_bus), 0);
    check("b_wrap_data", b_data, b_dat_c[0]);
    @(posedge clk); #1;
    b_snd = 3'b000;
    @(negedge clk);
    check("b_wrap_ack", W'(b_sack), 3'b001);
    check("b_wrap_ptr", W'(b_ptr), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_end_valid", W'(b_valid), 0);

    repeat (2) @(posedge clk);
    check("acks_outstanding", W'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uarc_receive_arbiter.md
Name: uarc_receive_arbiter

Overview:
- Receiver-side scheduler for core0's UARC buses.
- Watches kill/incept/send requests on all TOTAL_BUSES receiver buses and picks one at a time with round-robin fairness.
- Presents the chosen request to the core's dispatch logic over a valid/ready grant interface.
- Returns a single-cycle ack on the chosen bus once the core accepts. It sits between core0's receiver_* ports and its interrupt/dispatch unit.

Parameters:
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
- TOTAL_BUSES, 4, number of receiver buses; must be >= 1; need not be a power of two.
- BUS_ADDR_WIDTH, localparam, max(1, clog2(TOTAL_BUSES)), width of the bus index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- receiver_enables  in  TOTAL_BUSES  bus i is connected and live.
- receiver_kills  in  TOTAL_BUSES  kill request per bus.
- receiver_kill_acks  out  TOTAL_BUSES  kill ack pulse per bus.
- receiver_incepts  in  TOTAL_BUSES  incept request per bus.
- receiver_incept_acks  out  TOTAL_BUSES  incept ack pulse per bus.
- receiver_sends  in  TOTAL_BUSES  send request per bus.
- receiver_send_acks  out  TOTAL_BUSES  send ack pulse per bus.
- receiver_datas  in  TOTAL_BUSES x WORD_WIDTH  packed send data per bus.
- receiver_incept_permissions  in  TOTAL_BUSES x WORD_WIDTH  packed incept permission per bus.
- receiver_incept_addresses  in  TOTAL_BUSES x WORD_WIDTH  packed incept address per bus.
- grant_valid  out  1  a request is offered to the core.
- grant_ready  in  1  the core accepts the offered request.
- grant_kind  out  2  0 = kill, 1 = incept, 2 = send (3 is never driven).
- grant_bus  out  BUS_ADDR_WIDTH  index of the granted bus.
- grant_data  out  WORD_WIDTH  latched receiver_datas[grant_bus].
- grant_permission  out  WORD_WIDTH  latched incept permission.
- grant_address  out  WORD_WIDTH  latched incept address.

Behaviour:
- Request on bus i: req[i] = enables[i] & (kills[i] | incepts[i] | sends[i]).
- Per-bus kind priority: kill > incept > send.
- States: IDLE, OFFER, ACK. Registers: state, ptr (BUS_ADDR_WIDTH), bus_q, kind_q, data_q, perm_q, addr_q.
- IDLE:
  - If any req, select the first requesting bus at or after ptr, searching upward with wrap at TOTAL_BUSES (not at 2^BUS_ADDR_WIDTH).
  - Latch its index, kind and the three words; go to OFFER.
  - If no req, stay in IDLE.
- OFFER:
  - still = enables[bus_q] & (request line of kind_q on bus_q).
  - grant_valid = still, combinational.
  - If still & grant_ready: go to ACK and set ptr = bus_q + 1, wrapping TOTAL_BUSES-1 -> 0.
  - If !still (sender retracted or bus disabled): go to IDLE, no ack, ptr unchanged.
  - Otherwise hold; latched fields stay stable while grant_valid is high.
- ACK:
  - Exactly one of the three ack vectors has only bit bus_q high, for one cycle, selected by kind_q.
  - Then IDLE unconditionally.
  - The sender must drop its request line on seeing the ack; the arbiter does not re-check it.
- Acks are registered (driven from state ACK), never combinational from inputs.
- Latency:
  - Request visible at edge 0 -> grant_valid from cycle 1.
  - Ready in cycle 1 -> ack in cycle 2 -> IDLE in cycle 3.
  - Next grant no earlier than cycle 4. Max throughput is 1 grant per 3 cycles.
- A new kill arriving on another bus during OFFER does not preempt the current offer.
- Simultaneous kill+incept+send on one bus: the kill is granted first. The incept is granted on a later round only if the lines remain asserted.
- Reset (any time, including OFFER/ACK):
  - state = IDLE, ptr = 0, all latched fields 0.
  - grant_valid = 0; all ack vectors = 0.
  - Any in-flight grant is dropped with no ack.
- grant_kind / grant_bus / grant_data / grant_permission / grant_address are don't-care when grant_valid = 0, but are 0 after reset.

Test Plan:
- Single send: TOTAL_BUSES = 4, bus 2 sends data 0xDEADBEEF, grant_ready tied 1 -> cycle 1: grant_valid = 1, kind = 2, bus = 2, data = 0xDEADBEEF; cycle 2: send_acks = 4'b0100 for one cycle; ptr = 3.
- Round-robin: buses 0, 1, 3 hold sends continuously, re-asserting after each ack, ready = 1 -> grant order 0, 1, 3, 0, 1, 3; no bus is granted twice before the others.
- Kind priority: bus 1 asserts kill, incept (perm 0x11, addr 0x2000) and send together -> first grant kind = 0 with kill_acks = 4'b0010. Then drop the kill -> next grant kind = 1 with permission 0x11, address 0x2000.
- Retraction and backpressure: grant_ready = 0 for 5 cycles -> grant_valid stays 1 with stable fields. Then bus drops its send while ready = 0 -> grant_valid = 0 next cycle, no ack, ptr unchanged.
- Disabled bus and wrap: TOTAL_BUSES = 3, ptr = 2, receiver_enables = 3'b011, all sends high -> bus 2 is ignored, bus 0 is granted, ptr becomes 1.
- Reset mid-operation: assert reset while in OFFER -> grant_valid and all acks = 0 immediately (asynchronous); after release, a pending request on bus 0 is granted 1 cycle later, with the ack only after a new handshake.
